// File: rtl/proc_reset_sequencer.sv
// Reset / clock-enable sequencer: hold all channels, release them staggered, then run.
// Optional RSTSEQ_SEQ_COUNT_EN adds seq_count, a saturating count of completed sequences.
module proc_reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int STAGGER     = 1,
  parameter int PERIOD_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PERIOD_W-1:0] period,
  output logic [NUM_CH-1:0]   ch_rst,
  output logic [NUM_CH-1:0]   ch_ce,
  output logic                busy,
  output logic                done
`ifdef RSTSEQ_SEQ_COUNT_EN
  ,output logic [7:0]         seq_count
`endif
);

  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam int REL_W    = $clog2((NUM_CH - 1) * STAGGER + 2);
  localparam int REL_LAST = (NUM_CH - 1) * STAGGER + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t              state, state_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_nx;
  logic [REL_W-1:0]    rel_cnt, rel_nx;
  logic [PERIOD_W-1:0] per_cnt, per_nx;
  logic [NUM_CH-1:0]   rst_nx, ce_nx;
  logic                busy_nx, done_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_ASSERT;
      hold_cnt <= '0;
      rel_cnt  <= '0;
      per_cnt  <= '0;
      ch_rst   <= '1;
      ch_ce    <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      rel_cnt  <= rel_nx;
      per_cnt  <= per_nx;
      ch_rst   <= rst_nx;
      ch_ce    <= ce_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    rel_nx   = rel_cnt;
    per_nx   = per_cnt;
    rst_nx   = ch_rst;
    ce_nx    = ch_ce;
    busy_nx  = busy;
    done_nx  = 1'b0;
    unique case (state)
      ST_ASSERT: begin
        rst_nx  = '1;
        ce_nx   = '0;
        busy_nx = 1'b1;
        per_nx  = '0;
        if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_nx = ST_RELEASE;
          hold_nx  = '0;
          rel_nx   = '0;
        end else begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      ST_RELEASE: begin
        busy_nx = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (rel_cnt == REL_W'(i * STAGGER)) rst_nx[i] = 1'b0;
        end
        // Enable trails the registered reset by one cycle per channel.
        ce_nx = ~ch_rst;
        if (rel_cnt == REL_W'(REL_LAST)) begin
          state_nx = ST_RUN;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          per_nx   = '0;
          rel_nx   = '0;
        end else begin
          rel_nx = rel_cnt + REL_W'(1);
        end
      end
      ST_RUN, ST_IDLE: begin
        rst_nx  = '0;
        ce_nx   = '1;
        busy_nx = 1'b0;
        // >= so a period shortened below the running count still expires.
        if (start || (state == ST_RUN && period != '0 &&
                      per_cnt >= period - PERIOD_W'(1))) begin
          state_nx = ST_ASSERT;
          hold_nx  = '0;
          per_nx   = '0;
          rst_nx   = '1;
          ce_nx    = '0;
          busy_nx  = 1'b1;
        end else if (period == '0) begin
          state_nx = ST_IDLE;
          per_nx   = '0;
        end else if (state == ST_IDLE) begin
          state_nx = ST_RUN;
          per_nx   = '0;
        end else begin
          per_nx = per_cnt + PERIOD_W'(1);
        end
      end
      default: begin
        state_nx = ST_ASSERT;
        hold_nx  = '0;
        rst_nx   = '1;
        ce_nx    = '0;
        busy_nx  = 1'b1;
      end
    endcase
  end

`ifdef RSTSEQ_SEQ_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_count <= '0;
    end else if (done_nx && seq_count != 8'hFF) begin
      seq_count <= seq_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_proc_reset_sequencer.sv
// Directed bench for proc_reset_sequencer (defaults NUM_CH=4, HOLD_CYCLES=2, STAGGER=1).
// Define RSTSEQ_SEQ_COUNT_EN to also exercise seq_count.
module tb_proc_reset_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] period;
  logic [3:0]  ch_rst;
  logic [3:0]  ch_ce;
  logic        busy;
  logic        done;
`ifdef RSTSEQ_SEQ_COUNT_EN
  logic [7:0]  seq_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected outputs j edges after ASSERT is entered with hold counter 0.
  logic [3:0] exp_rst  [1:8] = '{4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] exp_ce   [1:8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
  logic       exp_busy [1:8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       exp_done [1:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  proc_reset_sequencer #(
    .NUM_CH     (4),
    .HOLD_CYCLES(2),
    .STAGGER    (1),
    .PERIOD_W   (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .period   (period),
    .ch_rst   (ch_rst),
    .ch_ce    (ch_ce),
    .busy     (busy),
    .done     (done)
`ifdef RSTSEQ_SEQ_COUNT_EN
    ,.seq_count(seq_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; period = '0;
    repeat (3) step();
    n_cmp++;
    if ({ch_rst, ch_ce, busy, done} !== {4'b1111, 4'b0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: rst=%b ce=%b busy=%b done=%b, required 1111 0000 1 0", ch_rst, ch_ce, busy, done);
    end
    reset = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      n_cmp++;
      if ({ch_rst, ch_ce, busy, done} !== {exp_rst[j], exp_ce[j], exp_busy[j], exp_done[j]}) begin
        n_fail++;
        $display("FAIL power_on_edge%0d: rst=%b ce=%b busy=%b done=%b, required %b %b %b %b",
                 j, ch_rst, ch_ce, busy, done, exp_rst[j], exp_ce[j], exp_busy[j], exp_done[j]);
      end
    end
    repeat (5) step();
    n_cmp++;
    if ({ch_rst, ch_ce, busy, done} !== {4'b0000, 4'b1111, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_settle: rst=%b ce=%b busy=%b done=%b, required 0000 1111 0 0", ch_rst, ch_ce, busy, done);
    end
  endtask

  task automatic test_periodic();
    period = 16'd10; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (ch_rst !== 4'b1111 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_start: rst=%b busy=%b, required 1111 1", ch_rst, busy);
    end
    for (int j = 1; j <= 7; j++) begin
      step();
      n_cmp++;
      if (ch_rst !== exp_rst[j] || done !== exp_done[j]) begin
        n_fail++;
        $display("FAIL periodic_seq_edge%0d: rst=%b done=%b, required %b %b", j, ch_rst, done, exp_rst[j], exp_done[j]);
      end
    end
    for (int k = 1; k <= 17; k++) begin
      step();
      n_cmp++;
      if (busy !== (k >= 10 && k <= 16) || done !== (k == 17)) begin
        n_fail++;
        $display("FAIL periodic_run_k%0d: busy=%b done=%b, required %b %b", k, busy, done, (k >= 10 && k <= 16), (k == 17));
      end
      if (k == 9 || k == 10 || k == 13) begin
        n_cmp++;
        if (ch_rst !== (k == 9 ? 4'b0000 : (k == 10 ? 4'b1111 : 4'b1110))) begin
          n_fail++;
          $display("FAIL periodic_rst_k%0d: rst=%b", k, ch_rst);
        end
      end
    end
  endtask

  task automatic test_start_run();
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if ({ch_rst, ch_ce, busy} !== {4'b1111, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL start_in_run: rst=%b ce=%b busy=%b, required 1111 0000 1", ch_rst, ch_ce, busy);
    end
    for (int j = 1; j <= 7; j++) begin
      start = (j == 1 || j == 4);
      step();
      start = 1'b0;
      n_cmp++;
      if ({ch_rst, ch_ce, done} !== {exp_rst[j], exp_ce[j], exp_done[j]}) begin
        n_fail++;
        $display("FAIL start_ignored_edge%0d: rst=%b ce=%b done=%b, required %b %b %b",
                 j, ch_rst, ch_ce, done, exp_rst[j], exp_ce[j], exp_done[j]);
      end
    end
  endtask

  task automatic test_start_expiry();
    int n_done;
    repeat (9) step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (ch_rst !== 4'b1111 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_at_expiry: rst=%b busy=%b, required 1111 1", ch_rst, busy);
    end
    n_done = 0;
    for (int j = 1; j <= 16; j++) begin
      step();
      if (done === 1'b1) n_done++;
      if (j <= 7) begin
        n_cmp++;
        if (ch_rst !== exp_rst[j] || done !== exp_done[j]) begin
          n_fail++;
          $display("FAIL expiry_seq_edge%0d: rst=%b done=%b, required %b %b", j, ch_rst, done, exp_rst[j], exp_done[j]);
        end
      end
    end
    n_cmp++;
    if (n_done != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL expiry_single_entry: done_pulses=%0d busy=%b, required 1 0", n_done, busy);
    end
    repeat (3) step();
    n_cmp++;
    if (ch_rst !== 4'b1111) begin
      n_fail++;
      $display("FAIL expiry_next_period: rst=%b, required 1111", ch_rst);
    end
    repeat (7) step();
  endtask

  task automatic test_period_change();
    repeat (5) step();
    period = 16'd3;
    step();
    n_cmp++;
    if (ch_rst !== 4'b1111 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL period_shrink: rst=%b busy=%b, required 1111 1", ch_rst, busy);
    end
    period = '0;
    repeat (7) step();
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL period_shrink_done: done=%b, required 1", done);
    end
    repeat (4) step();
    period = 16'd3;
    step();
    step();
    step();
    n_cmp++;
    if (ch_rst !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_to_run_count: rst=%b busy=%b, required 0000 0", ch_rst, busy);
    end
    step();
    n_cmp++;
    if (ch_rst !== 4'b1111) begin
      n_fail++;
      $display("FAIL idle_to_run_expire: rst=%b, required 1111", ch_rst);
    end
    period = '0;
    repeat (10) step();
  endtask

  task automatic test_async_mid();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    n_cmp++;
    if (ch_rst !== 4'b1100) begin
      n_fail++;
      $display("FAIL async_pre: rst=%b, required 1100", ch_rst);
    end
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if ({ch_rst, ch_ce, busy, done} !== {4'b1111, 4'b0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_immediate: rst=%b ce=%b busy=%b done=%b, required 1111 0000 1 0", ch_rst, ch_ce, busy, done);
    end
    step();
    reset = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      n_cmp++;
      if ({ch_rst, ch_ce, done} !== {exp_rst[j], exp_ce[j], exp_done[j]}) begin
        n_fail++;
        $display("FAIL async_restart_edge%0d: rst=%b ce=%b done=%b, required %b %b %b",
                 j, ch_rst, ch_ce, done, exp_rst[j], exp_ce[j], exp_done[j]);
      end
    end
  endtask

`ifdef RSTSEQ_SEQ_COUNT_EN
  task automatic test_seq_count();
    reset = 1'b0; period = 16'd1;
    step();
    n_cmp++;
    if (seq_count !== 8'd0) begin
      n_fail++;
      $display("FAIL seq_count_reset: got %0d, required 0", seq_count);
    end
    reset = 1'b1;
    repeat (79) step();
    n_cmp++;
    if (seq_count !== 8'd10 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_count_ten: got %0d done=%b, required 10 1", seq_count, done);
    end
    repeat (2000) step();
    n_cmp++;
    if (seq_count !== 8'd255) begin
      n_fail++;
      $display("FAIL seq_count_saturate: got %0d, required 255", seq_count);
    end
    repeat (16) step();
    n_cmp++;
    if (seq_count !== 8'd255) begin
      n_fail++;
      $display("FAIL seq_count_hold: got %0d, required 255", seq_count);
    end
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if (seq_count !== 8'd0) begin
      n_fail++;
      $display("FAIL seq_count_clear: got %0d, required 0", seq_count);
    end
    step();
    reset = 1'b1;
    period = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_periodic();
    test_start_run();
    test_start_expiry();
    test_period_change();
    test_async_mid();
`ifdef RSTSEQ_SEQ_COUNT_EN
    test_seq_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_reset_sequencer.md
Name: proc_reset_sequencer

Overview:
- Synthesisable, parametrised reset/clock-enable sequencer for processor cores and their peripherals.
- Replaces hand-toggled reset with a fixed sequence per channel: hold, staggered release, then run.
- Optionally re-resets all channels periodically.
- Sits between the top-level clock/reset pins and up to NUM_CH downstream blocks, e.g. processorModule instances.

Parameters:
- NUM_CH, 4, number of reset/enable channels (1..16).
- HOLD_CYCLES, 2, cycles all channel resets are held after sequence entry (>=1).
- STAGGER, 1, cycles between successive channel releases (0 = all release together).
- PERIOD_W, 16, width of the periodic re-reset interval input.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low block reset.
- start  in  1  one-cycle request to run a full reset sequence.
- period  in  PERIOD_W  RUN cycles before an automatic re-reset; 0 disables.
- ch_rst  out  NUM_CH  active-high reset to downstream channel i.
- ch_ce  out  NUM_CH  clock enable to channel i.
- busy  out  1  high in ASSERT and RELEASE.
- done  out  1  one-cycle pulse on entry to RUN.

Behaviour:
- All outputs are registered.
- Async reset (reset=0):
  - state=ASSERT, ch_rst=all 1, ch_ce=0, busy=1, done=0, counters=0.
  - On deassertion, the sequence starts automatically (power-on sequence); no start pulse is needed.
- States IDLE, ASSERT, RELEASE, RUN. IDLE is entered only from RUN when period=0 and no start is pending; IDLE behaves like RUN but its counter is frozen.
- ASSERT:
  - ch_rst=all 1, ch_ce=0, busy=1.
  - hold counter counts 0..HOLD_CYCLES-1, then moves to RELEASE.
  - start is ignored.
- RELEASE:
  - rel counter starts at 0 on entry.
  - ch_rst[i] clears at the edge where rel counter = i*STAGGER.
  - ch_ce[i] rises one cycle after ch_rst[i] clears.
  - With STAGGER=0, all channels clear on the first RELEASE edge.
  - After the last channel's ch_ce rises, moves to RUN; done=1 for exactly that one cycle.
  - start is ignored.
- RUN:
  - ch_rst=0, ch_ce=all 1, busy=0.
  - period counter increments each cycle.
  - start=1 → ASSERT next cycle; all ch_rst assert together, all ch_ce drop together.
  - period!=0 and counter = period-1 → ASSERT next cycle; counter clears.
  - start coincident with expiry → one ASSERT entry only.
  - period changed mid-RUN: the new value takes effect immediately. If counter >= new period-1, re-reset on the next cycle.
  - period=0 → counter held at 0, go to IDLE.
- IDLE:
  - Same outputs as RUN.
  - start → ASSERT.
  - period becoming non-zero → RUN with counter 0.
- Async reset mid-sequence overrides everything and restarts from ASSERT.
- Counter widths: hold counter ceil(log2(HOLD_CYCLES+1)); rel counter ceil(log2((NUM_CH-1)*STAGGER+2)).
- Counters wrap only via the state transitions above; no overflow is possible.

Optional Feature:
- Macro RSTSEQ_SEQ_COUNT_EN.
- Defined:
  - Adds output seq_count [7:0], an 8-bit count of completed sequences.
  - Increments on each done pulse; saturates at 255.
  - Cleared only by async reset.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Power-on, defaults (NUM_CH=4, HOLD_CYCLES=2, STAGGER=1), period=0:
  - reset low 3 cycles then high → ch_rst=1111 for 2 edges.
  - ch_rst then clears to 1110, 1100, 1000, 0000 on successive edges; ch_ce follows one cycle later.
  - done pulses once; state settles in IDLE.
- Periodic re-reset, period=10:
  - after done, exactly 10 RUN cycles, then ch_rst=1111 and busy=1.
  - sequence repeats every 10 RUN + 2 hold + 5 release cycles.
- start in RUN → ch_rst=1111 next cycle. start pulsed during ASSERT and during RELEASE → no change to sequence timing.
- period=10, start asserted on the cycle the counter equals 9 → single ASSERT entry; done pulses only once per sequence.
- Async reset pulled low during RELEASE (ch_rst=1100) → ch_rst=1111 and ch_ce=0000 immediately, without waiting for a clock edge; the full sequence restarts on release.
- With RSTSEQ_SEQ_COUNT_EN, period=1:
  - seq_count reaches 255 and stays at 255.
  - async reset clears it to 0.
- Without the macro: the bench compiles without seq_count, and all other checks pass.
